// File: rtl/axi_lite_master_arbiter.sv
// rtl/axi_lite_master_arbiter.sv - two-port round-robin Avalon-MM arbiter in front of the AXI4-Lite master wrapper
// One transaction outstanding at a time; reads are bounded by a completion timeout.
module axi_lite_master_arbiter #(
  parameter int                      C_ADDR_WIDTH   = 32,
  parameter int                      C_DATA_WIDTH   = 32,
  parameter int                      C_TIMEOUT      = 1024,
  parameter logic [C_DATA_WIDTH-1:0] C_TIMEOUT_DATA = 32'hDEADDEAD
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      r0_read,
  input  logic                      r0_write,
  input  logic [C_ADDR_WIDTH-1:0]   r0_addr,
  input  logic [C_DATA_WIDTH/8-1:0] r0_be,
  input  logic [C_DATA_WIDTH-1:0]   r0_wdata,
  output logic                      r0_waitreq,
  output logic                      r0_readvalid,
  output logic [C_DATA_WIDTH-1:0]   r0_readdata,
  input  logic                      r1_read,
  input  logic                      r1_write,
  input  logic [C_ADDR_WIDTH-1:0]   r1_addr,
  input  logic [C_DATA_WIDTH/8-1:0] r1_be,
  input  logic [C_DATA_WIDTH-1:0]   r1_wdata,
  output logic                      r1_waitreq,
  output logic                      r1_readvalid,
  output logic [C_DATA_WIDTH-1:0]   r1_readdata,
  output logic                      avalonRead,
  output logic                      avalonWrite,
  output logic [C_ADDR_WIDTH-1:0]   avalonAddr,
  output logic [C_DATA_WIDTH/8-1:0] avalonBE,
  output logic [C_DATA_WIDTH-1:0]   avalonWriteData,
  output logic                      avalonBeginTransfer,
  input  logic                      avalonWaitReq,
  input  logic                      avalonReadValid,
  input  logic [C_DATA_WIDTH-1:0]   avalonReadData,
  output logic                      timeout_err,
  output logic [1:0]                test_arb_state,
  output logic                      test_grant
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CMD    = 2'b01,
    S_RDWAIT = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  localparam logic [31:0] TO_LAST = (C_TIMEOUT > 0) ? 32'(C_TIMEOUT - 1) : 32'd0;

  state_t                    state_q, state_d;
  logic                      last_q, last_d;
  logic                      grant_q, grant_d;
  logic                      is_read_q, is_read_d;
  logic                      first_q, first_d;
  logic                      timeout_q, timeout_d;
  logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_DATA_WIDTH/8-1:0] be_q, be_d;
  logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [31:0]               cnt_q, cnt_d;
  logic                      req0, req1, sel;
  logic                      in_cmd, done0, done1;

  assign req0 = r0_read | r0_write;
  assign req1 = r1_read | r1_write;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    is_read_d = is_read_q;
    first_d   = 1'b0;
    timeout_d = 1'b0;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    sel       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the port not granted last wins.
          sel       = (req0 && req1) ? ~last_q : req1;
          grant_d   = sel;
          last_d    = sel;
          is_read_d = sel ? r1_read : r0_read;
          addr_d    = sel ? r1_addr : r0_addr;
          be_d      = sel ? r1_be : r0_be;
          wdata_d   = sel ? r1_wdata : r0_wdata;
          first_d   = 1'b1;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (!avalonWaitReq) begin
          cnt_d   = 32'd0;
          state_d = is_read_q ? S_RDWAIT : S_DONE;
        end
      end
      S_RDWAIT: begin
        if (avalonReadValid) begin
          rdata_d = avalonReadData;
          state_d = S_DONE;
        end else if (C_TIMEOUT != 0 && cnt_q == TO_LAST) begin
          rdata_d   = C_TIMEOUT_DATA;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      is_read_q <= 1'b0;
      first_q   <= 1'b0;
      timeout_q <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      is_read_q <= is_read_d;
      first_q   <= first_d;
      timeout_q <= timeout_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  // Everything below decodes registered state, so reset reaches the outputs without a clock.
  assign in_cmd              = (state_q == S_CMD);
  assign avalonRead          = in_cmd & is_read_q;
  assign avalonWrite         = in_cmd & ~is_read_q;
  assign avalonAddr          = in_cmd ? addr_q : '0;
  assign avalonBE            = in_cmd ? be_q : '0;
  assign avalonWriteData     = in_cmd ? wdata_q : '0;
  assign avalonBeginTransfer = in_cmd & first_q;

  assign done0        = (state_q == S_DONE) & ~grant_q;
  assign done1        = (state_q == S_DONE) & grant_q;
  assign r0_waitreq   = ~done0;
  assign r1_waitreq   = ~done1;
  assign r0_readvalid = done0 & is_read_q;
  assign r1_readvalid = done1 & is_read_q;
  assign r0_readdata  = r0_readvalid ? rdata_q : '0;
  assign r1_readdata  = r1_readvalid ? rdata_q : '0;

  assign timeout_err    = timeout_q;
  assign test_arb_state = state_q;
  assign test_grant     = grant_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb/tb_axi_lite_master_arbiter.sv - directed self-checking bench for axi_lite_master_arbiter
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_axi_lite_master_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_be, r1_be;
  logic        r0_waitreq, r0_readvalid, r1_waitreq, r1_readvalid;
  logic [31:0] r0_readdata, r1_readdata;
  logic        av_read, av_write, av_begin;
  logic [31:0] av_addr, av_wdata;
  logic [3:0]  av_be;
  logic        av_waitreq, av_readvalid;
  logic [31:0] av_readdata;
  logic        timeout_err;
  logic [1:0]  arb_state;
  logic        grant;

  int tests;
  int fails;

  axi_lite_master_arbiter #(
    .C_ADDR_WIDTH(32), .C_DATA_WIDTH(32), .C_TIMEOUT(16), .C_TIMEOUT_DATA(32'hDEADDEAD)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_be(r0_be),
    .r0_wdata(r0_wdata), .r0_waitreq(r0_waitreq), .r0_readvalid(r0_readvalid),
    .r0_readdata(r0_readdata),
    .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_be(r1_be),
    .r1_wdata(r1_wdata), .r1_waitreq(r1_waitreq), .r1_readvalid(r1_readvalid),
    .r1_readdata(r1_readdata),
    .avalonRead(av_read), .avalonWrite(av_write), .avalonAddr(av_addr), .avalonBE(av_be),
    .avalonWriteData(av_wdata), .avalonBeginTransfer(av_begin),
    .avalonWaitReq(av_waitreq), .avalonReadValid(av_readvalid), .avalonReadData(av_readdata),
    .timeout_err(timeout_err), .test_arb_state(arb_state), .test_grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    r0_read = 0; r0_write = 0; r1_read = 0; r1_write = 0;
    r0_addr = 0; r0_wdata = 0; r0_be = 0; r1_addr = 0; r1_wdata = 0; r1_be = 0;
    av_waitreq = 0; av_readvalid = 0; av_readdata = 0;
    @(negedge clk);
    tests++; if (arb_state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b expected 00", arb_state); end
    tests++; if ({r0_waitreq, r1_waitreq} !== 2'b11) begin fails++; $display("FAIL reset_waitreq: got %b expected 11", {r0_waitreq, r1_waitreq}); end
    tests++; if ({av_read, av_write, av_begin, timeout_err, grant, r0_readvalid, r1_readvalid} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000000", {av_read, av_write, av_begin, timeout_err, grant, r0_readvalid, r1_readvalid}); end
    tests++; if ({av_addr, av_wdata, av_be, r0_readdata, r1_readdata} !== '0) begin fails++; $display("FAIL reset_data: got nonzero expected zero"); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_p0();
    r0_write = 1; r0_addr = 32'hC7000000; r0_wdata = 32'h12345678; r0_be = 4'hF; av_waitreq = 0;
    @(negedge clk);
    tests++; if ({arb_state, av_write, av_read, av_begin} !== 5'b01101) begin fails++; $display("FAIL wr_cmd_ctrl: got %b expected 01101", {arb_state, av_write, av_read, av_begin}); end
    tests++; if ({av_addr, av_wdata, av_be} !== {32'hC7000000, 32'h12345678, 4'hF}) begin
      fails++; $display("FAIL wr_cmd_fields: got %h %h %h expected c7000000 12345678 f", av_addr, av_wdata, av_be); end
    tests++; if ({r0_waitreq, r1_waitreq} !== 2'b11) begin fails++; $display("FAIL wr_cmd_waitreq: got %b expected 11", {r0_waitreq, r1_waitreq}); end
    @(negedge clk);
    tests++; if ({arb_state, r0_waitreq, r1_waitreq, av_write, r0_readvalid} !== 6'b110100) begin
      fails++; $display("FAIL wr_done: got %b expected 110100", {arb_state, r0_waitreq, r1_waitreq, av_write, r0_readvalid}); end
    r0_write = 0;
    @(negedge clk);
    tests++; if ({arb_state, r0_waitreq, av_write} !== 4'b0010) begin fails++; $display("FAIL wr_idle: got %b expected 0010", {arb_state, r0_waitreq, av_write}); end
  endtask

  task automatic test_read_p1();
    r1_read = 1; r1_addr = 32'hC7000004; r1_be = 4'hF; av_waitreq = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      tests++; if ({arb_state, av_read, av_write, av_begin, av_addr} !== {2'b01, 1'b1, 1'b0, (c == 1), 32'hC7000004}) begin
        fails++; $display("FAIL rd_hold c%0d: got %b %b%b%b %h expected 01 1 0 %0d c7000004", c, arb_state, av_read, av_write, av_begin, av_addr, (c == 1)); end
    end
    @(negedge clk);
    av_waitreq = 0;
    @(negedge clk);
    tests++; if ({arb_state, av_read, r1_waitreq} !== 4'b1001) begin fails++; $display("FAIL rd_wait: got %b expected 1001", {arb_state, av_read, r1_waitreq}); end
    @(negedge clk);
    av_readvalid = 1; av_readdata = 32'hCAFEF00D;
    @(negedge clk);
    av_readvalid = 0; av_readdata = 0;
    tests++; if ({r1_readvalid, r1_waitreq, r1_readdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      fails++; $display("FAIL rd_done_p1: got %b %b %h expected 1 0 cafef00d", r1_readvalid, r1_waitreq, r1_readdata); end
    tests++; if ({r0_readvalid, r0_waitreq, r0_readdata} !== {1'b0, 1'b1, 32'h0}) begin
      fails++; $display("FAIL rd_done_p0: got %b %b %h expected 0 1 0", r0_readvalid, r0_waitreq, r0_readdata); end
    r1_read = 0;
    @(negedge clk);
    tests++; if ({arb_state, r1_readvalid, r1_waitreq} !== 4'b0001) begin fails++; $display("FAIL rd_after: got %b expected 0001", {arb_state, r1_readvalid, r1_waitreq}); end
  endtask

  task automatic test_back_to_back();
    logic g[8];
    int   n_cmd, n_done, ncyc, last_done, c0, c1;
    n_cmd = 0; n_done = 0; ncyc = 0; last_done = -1; c0 = 0; c1 = 0;
    r0_write = 1; r0_addr = 32'h100; r0_wdata = 32'hA0; r0_be = 4'h3;
    r1_write = 1; r1_addr = 32'h200; r1_wdata = 32'hB1; r1_be = 4'hC;
    av_waitreq = 0;
    while (n_done < 8 && ncyc < 100) begin
      @(negedge clk);
      ncyc++;
      if (arb_state == 2'b01 && n_cmd < 8) begin
        g[n_cmd] = grant;
        tests++; if (av_addr !== (grant ? 32'h200 : 32'h100)) begin fails++; $display("FAIL b2b_addr %0d: got %h grant %b", n_cmd, av_addr, grant); end
        n_cmd++;
      end
      if (!r0_waitreq) c0++;
      if (!r1_waitreq) c1++;
      if (arb_state == 2'b11) begin
        if (last_done >= 0) begin
          tests++; if (ncyc - last_done !== 3) begin fails++; $display("FAIL b2b_turnaround: got %0d expected 3", ncyc - last_done); end
        end
        last_done = ncyc;
        n_done++;
        if (n_done == 8) begin r0_write = 0; r1_write = 0; end
      end
    end
    r0_write = 0; r1_write = 0;
    tests++; if (n_done !== 8 || n_cmd !== 8) begin fails++; $display("FAIL b2b_budget: got %0d done %0d cmd expected 8 8", n_done, n_cmd); end
    for (int i = 0; i < n_cmd; i++) begin
      tests++; if (g[i] !== i[0]) begin fails++; $display("FAIL b2b_grant %0d: got %b expected %b", i, g[i], i[0]); end
    end
    tests++; if (c0 !== 4 || c1 !== 4) begin fails++; $display("FAIL b2b_counts: got %0d/%0d expected 4/4", c0, c1); end
    @(negedge clk);
    tests++; if (arb_state !== 2'b00) begin fails++; $display("FAIL b2b_idle: got %b expected 00", arb_state); end
  endtask

  task automatic test_timeout();
    int rdw, pulses, ncyc;
    logic [31:0] got;
    logic seen_done;
    rdw = 0; pulses = 0; ncyc = 0; got = 0; seen_done = 0;
    r0_read = 1; r0_addr = 32'hC7000010; av_waitreq = 0;
    while (!seen_done && ncyc < 40) begin
      @(negedge clk);
      ncyc++;
      if (arb_state == 2'b10) rdw++;
      if (timeout_err) pulses++;
      if (arb_state == 2'b11) begin seen_done = 1; got = r0_readdata; r0_read = 0; end
    end
    r0_read = 0;
    @(negedge clk);
    if (timeout_err) pulses++;
    tests++; if (!seen_done) begin fails++; $display("FAIL to_budget: got no DONE within 40 cycles expected DONE"); end
    tests++; if (rdw !== 16) begin fails++; $display("FAIL to_rdwait_cycles: got %0d expected 16", rdw); end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL to_pulses: got %0d expected 1", pulses); end
    tests++; if (got !== 32'hDEADDEAD) begin fails++; $display("FAIL to_data: got %h expected deaddead", got); end
    tests++; if (arb_state !== 2'b00) begin fails++; $display("FAIL to_idle: got %b expected 00", arb_state); end
  endtask

  task automatic test_reset_mid();
    r0_read = 1; r0_addr = 32'hC7000020; av_waitreq = 0;
    repeat (4) @(negedge clk);
    tests++; if ({arb_state, grant} !== 3'b100) begin fails++; $display("FAIL rst_pre: got %b expected 100", {arb_state, grant}); end
    rst_n = 0;
    #1;
    tests++; if ({arb_state, grant, r0_waitreq, r1_waitreq, av_read, av_write, av_begin, timeout_err} !== 9'b000110000) begin
      fails++; $display("FAIL rst_async: got %b expected 000110000", {arb_state, grant, r0_waitreq, r1_waitreq, av_read, av_write, av_begin, timeout_err}); end
    r0_read = 0;
    @(negedge clk);
    rst_n = 1;
    av_readvalid = 1; av_readdata = 32'h55AA55AA;
    @(negedge clk);
    av_readvalid = 0; av_readdata = 0;
    tests++; if ({arb_state, r0_readvalid, r1_readvalid, r0_waitreq, r1_waitreq} !== 6'b000011) begin
      fails++; $display("FAIL rst_late_rv: got %b expected 000011", {arb_state, r0_readvalid, r1_readvalid, r0_waitreq, r1_waitreq}); end
    r0_write = 1; r0_addr = 32'h300; r1_write = 1; r1_addr = 32'h400;
    @(negedge clk);
    tests++; if ({arb_state, grant, av_addr} !== {2'b01, 1'b0, 32'h300}) begin
      fails++; $display("FAIL rst_tie: got %b %b %h expected 01 0 300", arb_state, grant, av_addr); end
    r1_write = 0;
    @(negedge clk);
    r0_write = 0;
    @(negedge clk);
  endtask

  task automatic test_read_write_both();
    int nr, nw, ncyc;
    logic ok;
    nr = 0; nw = 0; ncyc = 0; ok = 0;
    r1_read = 1; r1_write = 1; r1_addr = 32'hC7000030; av_waitreq = 0;
    while (!ok && ncyc < 20) begin
      @(negedge clk);
      ncyc++;
      av_readvalid = 0; av_readdata = 0;
      if (av_read) nr++;
      if (av_write) nw++;
      if (arb_state == 2'b10) begin av_readvalid = 1; av_readdata = 32'h0BADBEEF; end
      if (arb_state == 2'b11) begin
        ok = 1;
        tests++; if ({r1_readvalid, r1_readdata} !== {1'b1, 32'h0BADBEEF}) begin
          fails++; $display("FAIL rw_data: got %b %h expected 1 0badbeef", r1_readvalid, r1_readdata); end
        r1_read = 0; r1_write = 0;
      end
    end
    r1_read = 0; r1_write = 0; av_readvalid = 0;
    tests++; if (!ok) begin fails++; $display("FAIL rw_budget: got no DONE within 20 cycles expected DONE"); end
    tests++; if (nr !== 1 || nw !== 0) begin fails++; $display("FAIL rw_cmd: got read %0d write %0d expected 1 0", nr, nw); end
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_write_p0();
    test_read_p1();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_read_write_both();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_arbiter.md
# axi_lite_master_arbiter

Two-port round-robin arbiter that shares the single Avalon-side command port of the AXI4-Lite master wrapper between two Avalon-MM requesters. Sits between requesters (e.g. the test `avalon_master` and a CPU-side register block) and the wrapper's `avalon*` inputs. Issues one transaction at a time, registers each command, and returns read data to the granted requester. Includes a read-completion timeout so a hung slave cannot lock out both requesters.

## Interface
Parameters:
- `C_ADDR_WIDTH`, 32, address width of all ports.
- `C_DATA_WIDTH`, 32, data width; byte-enable width is `C_DATA_WIDTH/8`.
- `C_TIMEOUT`, 1024, maximum `RDWAIT` cycles before forced completion; 0 disables the timeout.
- `C_TIMEOUT_DATA`, 32'hDEADDEAD, read data returned on timeout.

Ports (one clock; reset is asynchronous and active-low):
- `M_AXI_ACLK` in 1: clock.
- `M_AXI_ARESETN` in 1: asynchronous active-low reset.
- `r0_read`, `r0_write` in 1: requester 0 command; held until `r0_waitreq` is low.
- `r0_addr` in C_ADDR_WIDTH, `r0_be` in C_DATA_WIDTH/8, `r0_wdata` in C_DATA_WIDTH: requester 0 command fields.
- `r0_waitreq` out 1: low for exactly one cycle when requester 0's transaction completes.
- `r0_readvalid` out 1, `r0_readdata` out C_DATA_WIDTH: read completion to requester 0.
- `r1_*`: identical set for requester 1.
- `avalonRead`, `avalonWrite` out 1: command to the wrapper.
- `avalonAddr` out C_ADDR_WIDTH, `avalonBE` out C_DATA_WIDTH/8, `avalonWriteData` out C_DATA_WIDTH.
- `avalonBeginTransfer` out 1: high during the first `CMD` cycle only.
- `avalonWaitReq` in 1, `avalonReadValid` in 1, `avalonReadData` in C_DATA_WIDTH: wrapper responses.
- `timeout_err` out 1: one-cycle pulse on read timeout.
- `test_arb_state` out 2: FSM state encoding; `test_grant` out 1: current or last grant.

## Operation
- FSM states: `IDLE` (00), `CMD` (01), `RDWAIT` (10), `DONE` (11).
- `IDLE`: if any `rN_read|rN_write` is high, grant one port, latch its addr/be/wdata/type into registers, then go to `CMD`.
  - Round-robin: with both ports requesting, grant the port not granted last. The last-grant pointer resets to 1, so port 0 wins the first tie.
- `CMD`: drive `avalonRead` or `avalonWrite` and the fields from the registers. The command is accepted in a cycle where `avalonWaitReq`=0.
  - On acceptance, a write goes to `DONE` and a read goes to `RDWAIT`.
  - While `avalonWaitReq`=1, hold all outputs stable.
- `RDWAIT`: command outputs are low. On `avalonReadValid`=1, capture `avalonReadData` and go to `DONE`.
  - The timeout counter starts at 0 on entry. If it reaches `C_TIMEOUT`-1 without `avalonReadValid`, capture `C_TIMEOUT_DATA`, pulse `timeout_err`, and go to `DONE`.
  - `avalonReadValid` outside `RDWAIT` is ignored.
- `DONE`: one cycle. Granted `rN_waitreq`=0. For reads, also drive `rN_readvalid`=1 and `rN_readdata`=captured data. Then return to `IDLE`.
- The non-granted port always sees `waitreq`=1 and `readvalid`=0.
- If `read` and `write` are both high, the arbiter treats the command as a read.
- A requester that drops its request while waiting still completes the latched transaction; no cancellation.

## Timing
- Reset values:
  - all `avalon*` outputs 0, `avalonBeginTransfer` 0
  - `rN_waitreq` 1, `rN_readvalid` 0, `rN_readdata` 0
  - `timeout_err` 0, `test_arb_state` 00, `test_grant` 0
  - FSM in `IDLE`, last-grant pointer 1
- Reset asserted mid-transaction aborts immediately; outputs take reset values asynchronously. No completion is returned.
- Write with zero wait: request sampled in `IDLE` at edge 0. `CMD` occupies cycle 1. `DONE` occupies cycle 2, with `rN_waitreq` low. `IDLE` in cycle 3.
- Minimum turnaround is 3 cycles per write.
- Read: `DONE` occurs the cycle after `avalonReadValid`, giving a minimum of 4 cycles.
- `IDLE` never samples a request in the same cycle as `DONE`, so a held request is not re-granted twice.
- Only one transaction is outstanding at a time.

## Test plan
- Port 0 writes addr 0xC7000000, data 0x12345678, BE 0xF; wrapper waitreq=0 -> `avalonWrite` high for 1 cycle with those fields, `avalonBeginTransfer` high that cycle, `r0_waitreq` low exactly at cycle 2, port 1 untouched.
- Port 1 reads 0xC7000004; waitreq held 3 cycles; readvalid 2 cycles after acceptance with 0xCAFEF00D -> `r1_readvalid`=1, `r1_readdata`=0xCAFEF00D, `r1_waitreq`=0 in the same single cycle.
- Both ports issue writes continuously for 8 transactions -> grants alternate 0,1,0,1…; each port completes 4; `test_grant` toggles.
- Read with `C_TIMEOUT`=16 and no readvalid -> `timeout_err` pulses once; requester gets 0xDEADDEAD after 16 `RDWAIT` cycles; FSM returns to `IDLE`.
- Reset asserted during `RDWAIT` -> all outputs reach reset values without waiting for a clock. After release, a late `avalonReadValid` is ignored, and port 0 wins the next tie.
- Request with read=write=1 -> read issued, `avalonWrite` never asserted.
